// File: rtl/ea_unit_if.sv
// rtl/ea_unit_if.sv - request/response and memory-read bundle for ea_unit
//
// Purpose: groups the ea_unit request handshake, result outputs and the
// pointer-fetch memory read port into one bundle.
// Ports (through the modports):
//   master - the control FSM and memory side: drives start, IR, Ra, PC,
//            selEAB1, selEAB2, indirect, mem_ack, mem_data; observes ready,
//            mem_req, mem_addr, done, ea_out, fault.
//   slave  - the ea_unit side: the mirror image of master.
interface ea_unit_if #(
  parameter int WIDTH   = 16,
  parameter int OFF_L_W = 11
);
  logic               start;
  logic [OFF_L_W-1:0] IR;
  logic [WIDTH-1:0]   Ra;
  logic [WIDTH-1:0]   PC;
  logic               selEAB1;
  logic [1:0]         selEAB2;
  logic               indirect;
  logic               ready;
  logic               mem_req;
  logic [WIDTH-1:0]   mem_addr;
  logic               mem_ack;
  logic [WIDTH-1:0]   mem_data;
  logic               done;
  logic [WIDTH-1:0]   ea_out;
  logic               fault;

  modport master (
    output start, IR, Ra, PC, selEAB1, selEAB2, indirect, mem_ack, mem_data,
    input  ready, mem_req, mem_addr, done, ea_out, fault
  );

  modport slave (
    input  start, IR, Ra, PC, selEAB1, selEAB2, indirect, mem_ack, mem_data,
    output ready, mem_req, mem_addr, done, ea_out, fault
  );
endinterface

// File: rtl/ea_unit.sv
// rtl/ea_unit.sv - LC-3 effective-address unit with optional pointer fetch
//
// Purpose: computes base (PC or Ra) + sign-extended IR offset field. For
// indirect accesses the computed address is used for one memory read and the
// returned word becomes the final address. The result is presented on ea_out
// together with a one-cycle done pulse.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - ea_unit_if slave modport:
//           start/ready request handshake, IR/Ra/PC/selEAB1/selEAB2/indirect
//           operands, mem_req/mem_addr/mem_ack/mem_data pointer read,
//           done/ea_out/fault result.
// Configuration macro: EA_ACK_TIMEOUT_EN - when defined, a pointer read that
//   sees no mem_ack for TIMEOUT cycles is abandoned and reported with fault.
module ea_unit #(
  parameter int WIDTH   = 16,
  parameter int OFF_S_W = 6,
  parameter int OFF_M_W = 9,
  parameter int OFF_L_W = 11,
  parameter int TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      reset,
  ea_unit_if.slave  bus
);

  // Offset fields are sign-extended into WIDTH, so each must be narrower.
  if (!(OFF_S_W < OFF_M_W && OFF_M_W < OFF_L_W && OFF_L_W < WIDTH))
    begin : gBadWidths
      $error("ea_unit: offset widths must increase and stay below WIDTH");
    end
  if (TIMEOUT < 1) begin : gBadTimeout
    $error("ea_unit: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;

  // Operands captured at start acceptance so the caller may change them.
  logic [OFF_L_W-1:0] irQ;
  logic [WIDTH-1:0]   raQ;
  logic [WIDTH-1:0]   pcQ;
  logic               sel1Q;
  logic [1:0]         sel2Q;
  logic               indQ;

  logic [WIDTH-1:0]   eaQ;
  logic [WIDTH-1:0]   eaOutQ;
  logic               readyQ;
  logic               memReqQ;
  logic               doneQ;

  logic [WIDTH-1:0]   baseSel;
  logic [WIDTH-1:0]   offExt;
  logic [WIDTH-1:0]   eaSum;

`ifdef EA_ACK_TIMEOUT_EN
  // waitCnt holds the number of ack-less REQ cycles already seen, so the
  // cycle in which it equals TIMEOUT-1 is the last one allowed.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]   waitCnt;
  logic               faultQ;
`endif

  always_comb begin
    baseSel = sel1Q ? raQ : pcQ;
    offExt  = '0;
    case (sel2Q)
      2'b01:   offExt = {{(WIDTH-OFF_S_W){irQ[OFF_S_W-1]}}, irQ[OFF_S_W-1:0]};
      2'b10:   offExt = {{(WIDTH-OFF_M_W){irQ[OFF_M_W-1]}}, irQ[OFF_M_W-1:0]};
      2'b11:   offExt = {{(WIDTH-OFF_L_W){irQ[OFF_L_W-1]}}, irQ};
      default: offExt = '0;
    endcase
    // Carry out of the top bit is dropped: addresses wrap modulo 2^WIDTH.
    eaSum = baseSel + offExt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      irQ     <= '0;
      raQ     <= '0;
      pcQ     <= '0;
      sel1Q   <= 1'b0;
      sel2Q   <= 2'b00;
      indQ    <= 1'b0;
      eaQ     <= '0;
      eaOutQ  <= '0;
      readyQ  <= 1'b1;
      memReqQ <= 1'b0;
      doneQ   <= 1'b0;
`ifdef EA_ACK_TIMEOUT_EN
      waitCnt <= '0;
      faultQ  <= 1'b0;
`endif
    end else begin
      doneQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            irQ    <= bus.IR;
            raQ    <= bus.Ra;
            pcQ    <= bus.PC;
            sel1Q  <= bus.selEAB1;
            sel2Q  <= bus.selEAB2;
            indQ   <= bus.indirect;
            readyQ <= 1'b0;
            state  <= CALC;
`ifdef EA_ACK_TIMEOUT_EN
            faultQ <= 1'b0;
`endif
          end
        end

        CALC: begin
          eaQ <= eaSum;
          if (indQ) begin
            memReqQ <= 1'b1;
            state   <= REQ;
`ifdef EA_ACK_TIMEOUT_EN
            waitCnt <= '0;
`endif
          end else begin
            eaOutQ <= eaSum;
            doneQ  <= 1'b1;
            state  <= DONE;
          end
        end

        REQ: begin
          // An ack always wins, even in the cycle that would time out.
          if (bus.mem_ack) begin
            eaOutQ  <= bus.mem_data;
            memReqQ <= 1'b0;
            doneQ   <= 1'b1;
            state   <= DONE;
          end
`ifdef EA_ACK_TIMEOUT_EN
          else if (waitCnt == CNT_LAST) begin
            // Give up on the pointer; report the pointer address itself.
            eaOutQ  <= eaQ;
            memReqQ <= 1'b0;
            doneQ   <= 1'b1;
            faultQ  <= 1'b1;
            state   <= DONE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
`endif
        end

        DONE: begin
          readyQ <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          readyQ  <= 1'b1;
          memReqQ <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = readyQ;
  assign bus.mem_req  = memReqQ;
  assign bus.mem_addr = eaQ;
  assign bus.done     = doneQ;
  assign bus.ea_out   = eaOutQ;
`ifdef EA_ACK_TIMEOUT_EN
  assign bus.fault    = faultQ;
`else
  assign bus.fault    = 1'b0;
`endif

endmodule

// File: doc/ea_unit.md
# ea_unit

Parametrised, sequential effective-address unit for the LC-3 datapath. It computes base + sign-extended IR offset, with the base selected from PC or a register operand. For indirect loads and stores (LDI/STI) it also runs one memory read to fetch the pointer, using a req/ack handshake. It sits between the control FSM and the memory interface, and supplies the final address to MAR on a one-cycle `done` pulse.

## Interface

Parameters:
- `WIDTH`, 16, datapath and address width.
- `OFF_S_W`, 6, short offset field width, IR[OFF_S_W-1:0].
- `OFF_M_W`, 9, medium offset field width.
- `OFF_L_W`, 11, long offset field width; IR port width.
- `TIMEOUT`, 15, ack wait limit in cycles (used only with the macro).

Ports:
- `clk` in 1: the only clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request strobe; accepted only when `ready`=1.
- `IR` in OFF_L_W: instruction offset bits.
- `Ra` in WIDTH: register base.
- `PC` in WIDTH: PC base.
- `selEAB1` in 1: base select; 0 = PC, 1 = Ra.
- `selEAB2` in 2: offset select; 00 = zero, 01 = short, 10 = medium, 11 = long.
- `indirect` in 1: fetch the pointer at the computed address.
- `ready` out 1: high in IDLE.
- `mem_req` out 1: memory read request.
- `mem_addr` out WIDTH: read address; equals the computed EA.
- `mem_ack` in 1: read data valid.
- `mem_data` in WIDTH: read data.
- `done` out 1: one-cycle completion pulse.
- `ea_out` out WIDTH: final address; holds until the next `done`.
- `fault` out 1: timeout flag; valid with `done`.

## Operation

- States: IDLE, CALC, REQ, DONE.
- IDLE: `ready`=1. When `start`=1, latch IR, Ra, PC, selEAB1, selEAB2 and indirect, then go to CALC. `start` outside IDLE is ignored.
- CALC: the EA register is loaded with base + offset.
  - Offset is the selected field sign-extended to WIDTH; selEAB2=00 gives zero.
  - The sum is taken modulo 2^WIDTH; carry out is discarded.
  - Next state: REQ if the latched `indirect`=1, else DONE.
- REQ: `mem_req`=1 and `mem_addr`=EA, both held stable until `mem_ack`=1 is sampled.
  - On ack: `ea_out` ← `mem_data`, `mem_req` drops on the same edge, go to DONE.
  - An ack in the first REQ cycle is legal.
- DONE: `done`=1 for exactly one cycle, then IDLE.
  - For a direct access, `ea_out` = EA.
  - `ea_out` is written on the edge that enters DONE.
- `mem_ack` outside REQ is ignored.
- `mem_addr` shows EA in every state, but is meaningful only while `mem_req`=1.

## Timing

- Reset values: state IDLE, `ready`=1, `mem_req`=0, `done`=0, `fault`=0, `ea_out`=0, `mem_addr`=0.
- Direct access: `start` sampled at edge t → `done` high during cycle t+2. Back-to-back requests are possible every 3 cycles.
- Indirect access: `mem_req` rises in cycle t+2. If ack is sampled at edge t+2+k (k ≥ 0), `done` is high in cycle t+3+k.
- Reset asserted in any state, including mid-REQ, returns all outputs to their reset values on that edge. Any pending ack is lost and no `done` is issued.
- `start` arriving in the same cycle as `done` is ignored, because `ready`=0 in DONE.

## Configuration

- Macro `EA_ACK_TIMEOUT_EN`.
- Defined:
  - A counter clears on REQ entry and increments on each REQ cycle without ack.
  - After TIMEOUT consecutive REQ cycles without ack: drop `mem_req`, go to DONE, set `fault`=1 with `done`, and leave `ea_out` = EA (the pointer address).
  - `fault` clears on the next `start` acceptance.
  - An ack in the same cycle as the limit wins: normal completion, `fault`=0.
- Undefined: REQ waits indefinitely, `fault` is tied to 0, and no counter is built.

## Test plan

- Direct, PC base: PC=0x3000, IR[8:0]=0x1FF, selEAB2=10, selEAB1=0, start → `done` at t+2, `ea_out`=0x2FFF, `mem_req` never high.
- Direct, Ra base: Ra=0x4000, IR[5:0]=0x20, selEAB2=01, selEAB1=1 → `ea_out`=0x3FE0. With selEAB2=00 → `ea_out`=0x4000.
- Wrap-around: Ra=0xFFFF, IR[10:0]=0x001, selEAB2=11, selEAB1=1 → `ea_out`=0x0000.
- Indirect: PC=0x3000, IR[8:0]=0x005, indirect=1. Hold ack low for 3 cycles, then ack with `mem_data`=0xBEEF → `mem_addr`=0x3005 stable while `mem_req`=1, `ea_out`=0xBEEF, `done` one cycle after ack; a `start` pulsed mid-REQ is ignored.
- Reset mid-REQ: assert `reset` during the 2nd REQ cycle → next cycle `mem_req`=0, `done`=0, `ea_out`=0, `ready`=1.
- Timeout (macro defined, TIMEOUT=15): indirect with `mem_ack` never asserted → `mem_req` drops after 15 cycles, `done`=1 with `fault`=1, `ea_out`=pointer address. Repeat with ack arriving on the 15th cycle → `fault`=0.
